run_length_detector: RTL and testbench
======================================

Name: run_length_detector

Overview:
- Parametrised Moore sequence detector. Asserts z once input w has matched a target polarity for RUN_LEN consecutive sampled cycles.
- Generalises the 3-state "two consecutive 1s" detector:
  - configurable run length and polarity
  - overlapping or non-overlapping detection
  - sample enable and synchronous clear
  - one-cycle detection pulse and saturating detection counter
- Sits between a serial bit source and control/status logic in FSM lab designs.

Parameters:
- RUN_LEN, 2, consecutive matching samples required for detection; legal range >= 1.
- OVERLAP, 1, 1 = stay detecting while w keeps matching; 0 = restart the run after each detection.
- CNT_W, 8, width of the saturating detection counter.

Ports:
- Clock  input  1  rising-edge clock
- Resetn  input  1  asynchronous, active-low reset
- En  input  1  sample enable; w is sampled only when En=1
- Clr  input  1  synchronous clear of run and detection state
- Pol  input  1  target bit value to detect (1 = runs of ones, 0 = runs of zeros)
- w  input  1  serial data bit
- z  output  1  Moore output, high while in DETECT
- z_pulse  output  1  registered one-cycle pulse per detection event
- run_cnt  output  RW  current run length, RW = $clog2(RUN_LEN+1)
- det_cnt  output  CNT_W  saturating count of detection events

Behaviour:
- Reset (Resetn=0, asynchronous): r=0 (IDLE), z=0, z_pulse=0, run_cnt=0, det_cnt=0.
- State is derived from run register r (0..RUN_LEN):
  - IDLE: r=0
  - COUNT: 0<r<RUN_LEN
  - DETECT: r=RUN_LEN
- z = (r==RUN_LEN), decoded from registered state only; no combinational path from w, En or Pol.
- run_cnt = r.
- Per rising edge, priority order: Clr, then En.
  - Clr=1: r=0, det_cnt=0, z_pulse=0. Applies regardless of En.
  - Clr=0, En=0: r and det_cnt hold; z_pulse=0.
  - Clr=0, En=1, w!=Pol: r=0; z_pulse=0.
  - Clr=0, En=1, w==Pol:
    - OVERLAP=1: r = min(r+1, RUN_LEN).
    - OVERLAP=0: r = (r==RUN_LEN) ? 1 : r+1.
- Detection event: the enabled matching sample that makes r_next==RUN_LEN while either r!=RUN_LEN or OVERLAP=0.
  - On that same edge: z_pulse=1, and det_cnt += 1, saturating at 2^CNT_W-1 with no wrap.
- Latency: z and z_pulse rise on the edge that samples the RUN_LEN-th consecutive match.
- Special cases:
  - RUN_LEN=1: COUNT is unreachable.
  - RUN_LEN=1, OVERLAP=0: every enabled match is a detection; z stays high across consecutive matches, z_pulse fires each cycle.
- Pol is sampled each enabled cycle. Changing Pol mid-run affects the current sample only and gets no special handling; a mismatch returns r to 0.
- Non-enabled cycles do not break a run (run continuity counts enabled samples only).
- Reset mid-run: asynchronous return to IDLE; the first edge after deassertion is a normal sample.
- Elaboration error if RUN_LEN<1 or CNT_W<1.
- With RUN_LEN=2, OVERLAP=1, Pol=1, En=1, Clr=0, z is cycle-identical to the legacy A/B/C detector (A=IDLE, B=COUNT, C=DETECT).

Decomposition:
- Shared package rundet_pkg:
  - state encoding constants ST_IDLE=2'b00, ST_COUNT=2'b01, ST_DETECT=2'b10
  - function clog2 for RW sizing
- One sub-module: sat_counter, parameter W, with ports Clock, Resetn, clr, inc, q; saturating increment. Used for det_cnt.
- Run logic (next-state always block plus state register) stays in the top module.

Test Plan:
- Legacy equivalence: RUN_LEN=2, OVERLAP=1, Pol=1, w=0,1,1,1,0,1 over 6 edges -> z=0,0,1,1,0,0; z_pulse=0,0,1,0,0,0; det_cnt ends at 1.
- Non-overlap: RUN_LEN=3, OVERLAP=0, w=1 for 7 edges -> run_cnt=1,2,3,1,2,3,1; z high after edges 3 and 6 only; det_cnt=2.
- Enable gating and polarity: RUN_LEN=3, Pol=0, w=0 with En=1,0,1,1 -> run_cnt=1,1,2,3; z rises on edge 4; a following w=1 with En=1 -> run_cnt=0, z=0.
- Saturation: CNT_W=2, RUN_LEN=1, OVERLAP=0, w=1 for 5 edges -> det_cnt=1,2,3,3,3; z_pulse high on all 5 edges.
- Clear priority: in DETECT, assert Clr=1 with En=1, w==Pol -> next edge r=0, z=0, det_cnt=0, z_pulse=0.
- Async reset mid-run: RUN_LEN=4, run_cnt=3, pulse Resetn low between edges -> z, run_cnt and det_cnt go to 0 immediately without a clock edge; after release, 4 matches are needed to reach z=1.

Source files
------------

// File: rtl/rundet_pkg.sv
// Shared state encoding and sizing helper for the run-length detector.
package rundet_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_COUNT  = 2'b01,
      ST_DETECT = 2'b10
   } state_t;

   // Ceiling log2; evaluated at elaboration to size the run register.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/run_length_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         Clock,
   input  logic         Resetn,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/run_length_detector.sv
// Moore detector: z goes high once w has matched Pol for RUN_LEN consecutive enabled samples.
module run_length_detector
   import rundet_pkg::*;
#(
   parameter  int RUN_LEN = 2,
   parameter  int OVERLAP = 1,
   parameter  int CNT_W   = 8,
   localparam int RW      = clog2(RUN_LEN + 1)
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             En,
   input  logic             Clr,
   input  logic             Pol,
   input  logic             w,
   output logic             z,
   output logic             z_pulse,
   output logic [RW-1:0]    run_cnt,
   output logic [CNT_W-1:0] det_cnt
);

   localparam logic [RW-1:0] RUN_MAX = RW'(RUN_LEN);
   localparam logic [RW-1:0] RUN_ONE = RW'(1);

   generate
      if (RUN_LEN < 1 || CNT_W < 1) begin : g_bad_param
         $error("run_length_detector: RUN_LEN and CNT_W must both be >= 1");
      end
   endgenerate

   logic [RW-1:0] r_run;
   logic [RW-1:0] w_run_next;
   logic          r_pulse;
   logic          w_det;
   state_t        w_state;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_run   <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_run   <= w_run_next;
         r_pulse <= w_det;
      end
   end

   always_comb begin
      w_run_next = r_run;
      w_det      = 1'b0;
      if (Clr) begin
         w_run_next = '0;
      end else if (En) begin
         if (w != Pol) begin
            w_run_next = '0;
         end else if (r_run == RUN_MAX) begin
            // A completed run either stays in DETECT or restarts as a run of one.
            w_run_next = (OVERLAP != 0) ? RUN_MAX : RUN_ONE;
            w_det      = (OVERLAP == 0) && (RUN_LEN == 1);
         end else begin
            w_run_next = r_run + RUN_ONE;
            w_det      = ((r_run + RUN_ONE) == RUN_MAX);
         end
      end
   end

   always_comb begin
      w_state = ST_COUNT;
      if (r_run == '0) begin
         w_state = ST_IDLE;
      end else if (r_run == RUN_MAX) begin
         w_state = ST_DETECT;
      end
   end

   assign z       = (w_state == ST_DETECT);
   assign z_pulse = r_pulse;
   assign run_cnt = r_run;

   sat_counter #(
      .W (CNT_W)
   ) u_det_cnt (
      .Clock  (Clock),
      .Resetn (Resetn),
      .clr    (Clr),
      .inc    (w_det),
      .q      (det_cnt)
   );

endmodule

// File: tb/tb_run_length_detector.sv
// Bench for run_length_detector: six parameter sets driven in parallel, checked against a streak-based model.
module tb_run_length_detector;

   localparam int NI = 6;

   function automatic int cfg_rl(input int i);
      case (i)
         0: return 2;
         1: return 3;
         2: return 3;
         3: return 1;
         4: return 4;
         default: return 2;
      endcase
   endfunction

   function automatic int cfg_ov(input int i);
      case (i)
         0: return 1;
         1: return 0;
         2: return 1;
         3: return 0;
         4: return 1;
         default: return 0;
      endcase
   endfunction

   function automatic int cfg_cw(input int i);
      case (i)
         3: return 2;
         5: return 3;
         default: return 8;
      endcase
   endfunction

   logic Clock  = 1'b0;
   logic Resetn = 1'b1;
   logic en     = 1'b0;
   logic clr    = 1'b0;
   logic pol    = 1'b1;
   logic wb     = 1'b0;

   logic [7:0] run_obs [NI];
   logic [7:0] det_obs [NI];
   logic       z_obs   [NI];
   logic       p_obs   [NI];

   always #5 Clock = ~Clock;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int RL  = cfg_rl(gi);
      localparam int OV  = cfg_ov(gi);
      localparam int CW  = cfg_cw(gi);
      localparam int RWL = $clog2(RL + 1);
      logic [RWL-1:0] rc;
      logic [CW-1:0]  dc;
      logic           zz;
      logic           pp;

      run_length_detector #(
         .RUN_LEN (RL),
         .OVERLAP (OV),
         .CNT_W   (CW)
      ) u_dut (
         .Clock   (Clock),
         .Resetn  (Resetn),
         .En      (en),
         .Clr     (clr),
         .Pol     (pol),
         .w       (wb),
         .z       (zz),
         .z_pulse (pp),
         .run_cnt (rc),
         .det_cnt (dc)
      );

      assign run_obs[gi] = 8'(rc);
      assign det_obs[gi] = 8'(dc);
      assign z_obs[gi]   = zz;
      assign p_obs[gi]   = pp;
   end

   int checks = 0;
   int errors = 0;

   // Reference model: the length of the current streak of enabled matches and events seen.
   int streak = 0;
   int ev [NI];
   bit exp_pulse [NI];

   function automatic bit is_event(input int i, input int s);
      if (cfg_ov(i) != 0) return (s == cfg_rl(i));
      return ((s % cfg_rl(i)) == 0);
   endfunction

   function automatic int exp_run(input int i);
      int rl;
      rl = cfg_rl(i);
      if (streak == 0) return 0;
      if (cfg_ov(i) != 0) return (streak > rl) ? rl : streak;
      return ((streak - 1) % rl) + 1;
   endfunction

   function automatic int exp_det(input int i);
      int mx;
      mx = (1 << cfg_cw(i)) - 1;
      return (ev[i] > mx) ? mx : ev[i];
   endfunction

   task automatic model_reset();
      streak = 0;
      for (int i = 0; i < NI; i++) begin
         ev[i]        = 0;
         exp_pulse[i] = 1'b0;
      end
   endtask

   task automatic step(input logic e, input logic c, input logic p, input logic b);
      en  = e;
      clr = c;
      pol = p;
      wb  = b;
      @(posedge Clock);
      if (c) begin
         model_reset();
      end else if (e) begin
         streak = (b == p) ? streak + 1 : 0;
         for (int i = 0; i < NI; i++) begin
            exp_pulse[i] = (b == p) && is_event(i, streak);
            if (exp_pulse[i]) ev[i]++;
         end
      end else begin
         for (int i = 0; i < NI; i++) exp_pulse[i] = 1'b0;
      end
      #1;
   endtask

   task automatic apply_reset();
      en     = 1'b0;
      clr    = 1'b0;
      wb     = 1'b0;
      Resetn = 1'b0;
      repeat (2) @(posedge Clock);
      #2;
      Resetn = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      #2;
      Resetn = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (run_obs[i] !== 8'd0 || z_obs[i] !== 1'b0 || p_obs[i] !== 1'b0 || det_obs[i] !== 8'd0) begin
            errors++;
            $display("FAIL reset inst%0d got run=%0d z=%0b pulse=%0b det=%0d want all 0",
                     i, run_obs[i], z_obs[i], p_obs[i], det_obs[i]);
         end
      end
      #1;
      Resetn = 1'b1;
      model_reset();
      $display("reset: all instances idle");
   endtask

   task automatic test_legacy();
      logic w_seq [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic z_exp [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic p_exp [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      apply_reset();
      for (int k = 0; k < 6; k++) begin
         step(1'b1, 1'b0, 1'b1, w_seq[k]);
         checks++;
         if (z_obs[0] !== z_exp[k] || p_obs[0] !== p_exp[k]) begin
            errors++;
            $display("FAIL legacy edge%0d got z=%0b pulse=%0b want z=%0b pulse=%0b",
                     k + 1, z_obs[0], p_obs[0], z_exp[k], p_exp[k]);
         end
         $display("legacy edge%0d w=%0b z=%0b pulse=%0b", k + 1, w_seq[k], z_obs[0], p_obs[0]);
      end
      checks++;
      if (det_obs[0] !== 8'd1) begin
         errors++;
         $display("FAIL legacy_det got %0d want 1", det_obs[0]);
      end
   endtask

   task automatic test_non_overlap();
      int  run_exp [7] = '{1, 2, 3, 1, 2, 3, 1};
      logic z_exp  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      apply_reset();
      for (int k = 0; k < 7; k++) begin
         step(1'b1, 1'b0, 1'b1, 1'b1);
         checks++;
         if (run_obs[1] !== 8'(run_exp[k]) || z_obs[1] !== z_exp[k]) begin
            errors++;
            $display("FAIL non_overlap edge%0d got run=%0d z=%0b want run=%0d z=%0b",
                     k + 1, run_obs[1], z_obs[1], run_exp[k], z_exp[k]);
         end
         $display("non_overlap edge%0d run=%0d z=%0b", k + 1, run_obs[1], z_obs[1]);
      end
      checks++;
      if (det_obs[1] !== 8'd2) begin
         errors++;
         $display("FAIL non_overlap_det got %0d want 2", det_obs[1]);
      end
   endtask

   task automatic test_enable_polarity();
      logic en_seq  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      int   run_exp [4] = '{1, 1, 2, 3};
      logic z_exp   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         step(en_seq[k], 1'b0, 1'b0, 1'b0);
         checks++;
         if (run_obs[2] !== 8'(run_exp[k]) || z_obs[2] !== z_exp[k]) begin
            errors++;
            $display("FAIL enable_pol edge%0d got run=%0d z=%0b want run=%0d z=%0b",
                     k + 1, run_obs[2], z_obs[2], run_exp[k], z_exp[k]);
         end
         $display("enable_pol edge%0d en=%0b run=%0d z=%0b", k + 1, en_seq[k], run_obs[2], z_obs[2]);
      end
      step(1'b1, 1'b0, 1'b0, 1'b1);
      checks++;
      if (run_obs[2] !== 8'd0 || z_obs[2] !== 1'b0) begin
         errors++;
         $display("FAIL enable_pol_break got run=%0d z=%0b want run=0 z=0", run_obs[2], z_obs[2]);
      end
   endtask

   task automatic test_saturation();
      int det_exp [5] = '{1, 2, 3, 3, 3};
      apply_reset();
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 1'b0, 1'b1, 1'b1);
         checks++;
         if (det_obs[3] !== 8'(det_exp[k]) || p_obs[3] !== 1'b1 || z_obs[3] !== 1'b1) begin
            errors++;
            $display("FAIL saturation edge%0d got det=%0d pulse=%0b z=%0b want det=%0d pulse=1 z=1",
                     k + 1, det_obs[3], p_obs[3], z_obs[3], det_exp[k]);
         end
         $display("saturation edge%0d det=%0d pulse=%0b", k + 1, det_obs[3], p_obs[3]);
      end
   endtask

   task automatic test_clear_priority();
      apply_reset();
      step(1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      checks++;
      if (z_obs[0] !== 1'b1 || det_obs[0] !== 8'd1) begin
         errors++;
         $display("FAIL clear_setup got z=%0b det=%0d want z=1 det=1", z_obs[0], det_obs[0]);
      end
      step(1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if (run_obs[0] !== 8'd0 || z_obs[0] !== 1'b0 || det_obs[0] !== 8'd0 || p_obs[0] !== 1'b0) begin
         errors++;
         $display("FAIL clear_priority got run=%0d z=%0b det=%0d pulse=%0b want all 0",
                  run_obs[0], z_obs[0], det_obs[0], p_obs[0]);
      end
      $display("clear_priority run=%0d z=%0b det=%0d", run_obs[0], z_obs[0], det_obs[0]);
   endtask

   task automatic test_async_reset();
      apply_reset();
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 1'b1);
      checks++;
      if (run_obs[4] !== 8'd3 || det_obs[3] !== 8'd3) begin
         errors++;
         $display("FAIL async_setup got run=%0d det3=%0d want run=3 det3=3", run_obs[4], det_obs[3]);
      end
      Resetn = 1'b0;
      #1;
      checks++;
      if (run_obs[4] !== 8'd0 || z_obs[3] !== 1'b0 || det_obs[3] !== 8'd0) begin
         errors++;
         $display("FAIL async_reset got run=%0d z3=%0b det3=%0d want 0",
                  run_obs[4], z_obs[3], det_obs[3]);
      end
      #2;
      Resetn = 1'b1;
      model_reset();
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 1'b0, 1'b1, 1'b1);
         checks++;
         if (z_obs[4] !== (k == 3)) begin
            errors++;
            $display("FAIL async_rerun edge%0d got z=%0b want %0b", k + 1, z_obs[4], (k == 3));
         end
         $display("async_rerun edge%0d run=%0d z=%0b", k + 1, run_obs[4], z_obs[4]);
      end
   endtask

   task automatic test_random();
      logic p;
      logic e;
      logic c;
      logic b;
      apply_reset();
      p = 1'($urandom_range(1));
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(9) == 0) p = ~p;
         e = ($urandom_range(3) != 0);
         c = ($urandom_range(24) == 0);
         b = ($urandom_range(9) < 7) ? p : ~p;
         step(e, c, p, b);
         for (int i = 0; i < NI; i++) begin
            checks++;
            if (run_obs[i] !== 8'(exp_run(i)) || z_obs[i] !== (exp_run(i) == cfg_rl(i)) ||
                p_obs[i] !== exp_pulse[i] || det_obs[i] !== 8'(exp_det(i))) begin
               errors++;
               $display("FAIL random cyc%0d inst%0d got run=%0d z=%0b pulse=%0b det=%0d want run=%0d z=%0b pulse=%0b det=%0d",
                        n, i, run_obs[i], z_obs[i], p_obs[i], det_obs[i],
                        exp_run(i), (exp_run(i) == cfg_rl(i)), exp_pulse[i], exp_det(i));
            end
         end
         $display("random cyc%0d en=%0b clr=%0b pol=%0b w=%0b streak=%0d", n, e, c, p, b, streak);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_legacy();
      test_non_overlap();
      test_enable_polarity();
      test_saturation();
      test_clear_priority();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete within 200000 time units");
      $fatal(1, "timeout");
   end

endmodule
